// File: rtl/ex_wb_buffer.sv
//==============================================================================
// Module   : ex_wb_buffer
// Purpose  : 2-entry in-order skid buffer between the ALU output and
//            writeback. Optional result flags are enabled by EX_WB_FLAGS_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ex_wb_buffer #(
   parameter int bus_size      = 8,
   parameter int reg_addr_size = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [bus_size-1:0]      in_result,
   input  logic [reg_addr_size-1:0] in_dest,
   input  logic                     in_wr_en,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [bus_size-1:0]      out_result,
   output logic [reg_addr_size-1:0] out_dest,
   output logic                     out_wr_en,
   output logic                     out_zero,
   output logic                     out_neg,
   output logic [1:0]               count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic push;
   logic pop;
   logic load0_in;
   logic load0_shift;
   logic load1_in;

   // Slot 0 is always the head; slot 1 holds the younger entry when FULL.
   logic [bus_size-1:0]      result0, result1;
   logic [reg_addr_size-1:0] dest0,   dest1;
   logic                     wr_en0,  wr_en1;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      load0_in    = 1'b0;
      load0_shift = 1'b0;
      load1_in    = 1'b0;
      push        = in_valid && (state != FULL);
      pop         = out_ready && (state != EMPTY);
      case (state)
         EMPTY: begin
            if (push) begin
               state_nxt = ONE;
               load0_in  = 1'b1;
            end
         end
         ONE: begin
            if (push && pop) begin
               load0_in = 1'b1;
            end else if (push) begin
               state_nxt = FULL;
               load1_in  = 1'b1;
            end else if (pop) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               state_nxt   = ONE;
               load0_shift = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      // Flush discards everything, including a same-cycle push or pop.
      if (flush) begin
         state_nxt   = EMPTY;
         load0_in    = 1'b0;
         load0_shift = 1'b0;
         load1_in    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result0 <= '0;
         dest0   <= '0;
         wr_en0  <= 1'b0;
         result1 <= '0;
         dest1   <= '0;
         wr_en1  <= 1'b0;
      end else begin
         if (load0_in) begin
            result0 <= in_result;
            dest0   <= in_dest;
            wr_en0  <= in_wr_en;
         end else if (load0_shift) begin
            result0 <= result1;
            dest0   <= dest1;
            wr_en0  <= wr_en1;
         end
         if (load1_in) begin
            result1 <= in_result;
            dest1   <= in_dest;
            wr_en1  <= in_wr_en;
         end
      end
   end

`ifdef EX_WB_FLAGS_EN
   logic in_zero;
   logic in_neg;
   logic zero0, neg0, zero1, neg1;

   assign in_zero = (in_result == '0);
   assign in_neg  = in_result[bus_size-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zero0 <= 1'b0;
         neg0  <= 1'b0;
         zero1 <= 1'b0;
         neg1  <= 1'b0;
      end else begin
         if (load0_in) begin
            zero0 <= in_zero;
            neg0  <= in_neg;
         end else if (load0_shift) begin
            zero0 <= zero1;
            neg0  <= neg1;
         end
         if (load1_in) begin
            zero1 <= in_zero;
            neg1  <= in_neg;
         end
      end
   end

   assign out_zero = zero0;
   assign out_neg  = neg0;
`else
   assign out_zero = 1'b0;
   assign out_neg  = 1'b0;
`endif

   assign in_ready   = (state != FULL);
   assign out_valid  = (state != EMPTY);
   assign count      = state;
   assign out_result = result0;
   assign out_dest   = dest0;
   assign out_wr_en  = wr_en0;

endmodule

`default_nettype wire

// File: doc/ex_wb_buffer.md
EX_WB_BUFFER -- requirements
Module: ex_wb_buffer

Interface
REQ-001 SHALL have parameter bus_size, default 8, giving the data width of the ALU result bus.
REQ-002 SHALL have parameter reg_addr_size, default 3, giving the destination register address width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset that is synchronous and active-low.
REQ-005 SHALL have port flush, input, 1 bit, which discards all buffered entries.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning the ALU result is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit, meaning the buffer can accept an entry this cycle.
REQ-008 SHALL have ports in_result (input, bus_size), in_dest (input, reg_addr_size) and in_wr_en (input, 1), carrying the ALU result, the destination register and the register-write enable.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning the head entry is valid.
REQ-010 SHALL have port out_ready, input, 1 bit, meaning writeback consumes the head entry this cycle.
REQ-011 SHALL have ports out_result (output, bus_size), out_dest (output, reg_addr_size) and out_wr_en (output, 1), carrying the head entry.
REQ-012 SHALL have ports out_zero and out_neg, output, 1 bit each, carrying the head entry's flags.
REQ-013 SHALL have port count, output, 2 bits, giving the number of buffered entries (0..2).

Function
REQ-014 SHALL be a 2-entry in-order FIFO (skid buffer) between the ALU output and writeback, with states EMPTY (count=0), ONE (count=1) and FULL (count=2).
REQ-015 SHALL drive in_ready=1 iff count<2; the value depends only on registered state and does not combinationally depend on out_ready.
REQ-016 SHALL push when in_valid&&in_ready, and SHALL pop when out_valid&&out_ready.
REQ-017 SHALL drive out_valid=1 iff count>0; out_* always reflect the oldest entry, and their values are don't-care when count=0.
REQ-018 SHALL have latency of exactly 1 cycle: an entry pushed at edge N is presented on out_* after edge N.
REQ-019 SHALL make the following state transitions: EMPTY goes to ONE on push; ONE goes to FULL on push without pop, to EMPTY on pop without push, and stays in ONE on simultaneous push and pop; FULL goes to ONE on pop (no push is possible in FULL).
REQ-020 SHALL store entries whose in_wr_en=0 like any other entry, preserving their slot order.
REQ-021 SHALL keep out_* stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on flush=1, set count to 0 at the next edge, ignoring any same-cycle push and any same-cycle pop.
REQ-023 SHALL pass in_result through bit-exact with no arithmetic applied; widths are fixed by the parameters.
REQ-024 SHALL ignore in_* when in_valid=0 or in_ready=0, and ignore out_ready when out_valid=0.

Reset
REQ-025 SHALL, when rst_n=0 at a clock edge, set count=0, out_valid=0 and in_ready=1 (after the edge), with rst_n taking priority over flush, push and pop.
REQ-026 SHALL reset storage so that out_result=0, out_dest=0, out_wr_en=0, out_zero=0 and out_neg=0.
REQ-027 SHALL treat reset asserted mid-operation like flush: all entries are lost and no entry is presented afterward.

Configuration
REQ-028 SHALL, when macro EX_WB_FLAGS_EN is defined, compute per entry at push time zero=(in_result==0) and neg=in_result[bus_size-1], store them with the entry, and present them on out_zero/out_neg.
REQ-029 SHALL, when EX_WB_FLAGS_EN is undefined, include no flag storage and tie out_zero and out_neg to 0; the port list is unchanged.

Verification
REQ-030 SHALL cover a single entry: push result=0x2C, dest=5, wr_en=1 with out_ready=1 -> the next cycle shows out_valid=1, out_result=0x2C, out_dest=5, and count returns to 0 one cycle later.
REQ-031 SHALL cover backpressure: push 0x11, then 0x22, with out_ready=0 -> count=2 and in_ready=0; a third in_valid with 0x33 is not accepted; raise out_ready -> out shows 0x11 then 0x22.
REQ-032 SHALL cover simultaneous push and pop in ONE: holding 0x40 while pushing 0x41 with out_ready=1 -> count stays 1 and out_result becomes 0x41 the next cycle.
REQ-033 SHALL cover flush: count=2 with flush=1 and in_valid=1 (0x77) -> count=0 and out_valid=0 the next cycle, and 0x77 never appears on out_result.
REQ-034 SHALL cover reset: rst_n=0 for 1 cycle while count=2 -> count=0, out_valid=0, in_ready=1 and out_result=0.
REQ-035 SHALL cover flags with EX_WB_FLAGS_EN defined and bus_size=8: push 0x00, then 0x80 -> out_zero/out_neg read 1/0 for the first entry and 0/1 for the second; with the macro undefined, both read 0/0.
